// File: rtl/etpu_pkg.sv
// etpu_pkg: shared constants and state encoding for the systolic-array job sequencer.
//   ARRAY_SIZE / N_WWORDS / N_IWORDS / N_RES : array geometry and job sizes
//   WORD_W / IN_W                            : weight word and input word widths
//   seq_state_e                              : sequencer FSM encoding
package etpu_pkg;

  localparam int unsigned ARRAY_SIZE = 3;
  localparam int unsigned N_WWORDS   = 3;
  localparam int unsigned N_IWORDS   = 3;
  localparam int unsigned N_RES      = 9;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned IN_W       = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_LOAD_I = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/res_capture.sv
// res_capture: captures the three skewed array output columns into a 9-entry
// result buffer, one column per group of three entries.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_clr           : clear buffer and counters (job start)
//   i_en            : array advance enable as seen by the array this cycle
//   i_col0..i_col2  : array output columns
//   i_addr          : result read index
//   o_data_c        : combinational read of the buffer (0 when i_addr > 8)
//   o_fin_c         : all columns will be fully captured after this cycle
module res_capture
  import etpu_pkg::*;
#(
  parameter int unsigned OW  = 16,
  parameter int unsigned LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [OW-1:0] i_col0,
  input  logic [OW-1:0] i_col1,
  input  logic [OW-1:0] i_col2,
  input  logic [3:0]    i_addr,
  output logic [OW-1:0] o_data_c,
  output logic          o_fin_c
);

  logic [3:0]                     r_e_cnt;
  logic [ARRAY_SIZE-1:0][1:0]     r_c;
  logic [ARRAY_SIZE-1:0][OW-1:0]  w_col;
  logic [ARRAY_SIZE-1:0]          w_cap;
  logic [ARRAY_SIZE-1:0][1:0]     w_c_nx;
  logic [ARRAY_SIZE-1:0]          w_col_fin;
  logic [N_RES-1:0]               w_we;
  logic [N_RES-1:0][OW-1:0]       w_res;

  assign w_col = {i_col2, i_col1, i_col0};

  // Column k becomes valid LAT+k enabled cycles into the job (array skew).
  for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_col
    assign w_cap[k]     = i_en && ({28'd0, r_e_cnt} >= 32'(LAT + k)) && (r_c[k] != 2'd3);
    assign w_c_nx[k]    = r_c[k] + {1'b0, w_cap[k]};
    assign w_col_fin[k] = (w_c_nx[k] == 2'd3);
    for (genvar s = 0; s < N_IWORDS; s++) begin : g_slot
      assign w_we[k*N_IWORDS + s] = w_cap[k] && (r_c[k] == 2'(s));
    end
  end

  assign o_fin_c = &w_col_fin;

  // Enabled-cycle counter (saturating) and per-column capture counters.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_e_cnt <= '0;
      r_c     <= '0;
    end else if (i_en) begin
      r_c <= w_c_nx;
      if (r_e_cnt != 4'hF) r_e_cnt <= r_e_cnt + 4'd1;
    end
  end

  // One register per result entry.
  for (genvar j = 0; j < N_RES; j++) begin : g_res
    logic [OW-1:0] r_q;
    always_ff @(posedge clk) begin
      if (rst || i_clr)  r_q <= '0;
      else if (w_we[j])  r_q <= w_col[j / N_IWORDS];
    end
    assign w_res[j] = r_q;
  end

  assign o_data_c = (i_addr < 4'(N_RES)) ? w_res[i_addr] : '0;

endmodule

// File: rtl/sysa_seq.sv
// sysa_seq: single-clock job sequencer for the 3x3 systolic array. Loads three
// weight words and three input words over a valid/ready port, runs the drain
// phase and captures the skewed output columns into a readable result buffer.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   start                   : begin a job (IDLE/DONE only)
//   cfg_valid/ready/data    : word port (weights: 32 bits, inputs: [23:0])
//   busy, done              : job in progress, one-cycle completion pulse
//   sa_en, sa_w, sa_in      : array controls (registered)
//   sa_out1..sa_out3        : array output columns 0..2
//   res_addr, res_data      : result buffer read port (combinational data)
module sysa_seq
  import etpu_pkg::*;
#(
  parameter int unsigned OW  = 16,
  parameter int unsigned LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [WORD_W-1:0]          cfg_data,
  output logic                       busy,
  output logic                       done,
  output logic                       sa_en,
  output logic [N_WWORDS*WORD_W-1:0] sa_w,
  output logic [IN_W-1:0]            sa_in,
  input  logic [OW-1:0]              sa_out1,
  input  logic [OW-1:0]              sa_out2,
  input  logic [OW-1:0]              sa_out3,
  input  logic [3:0]                 res_addr,
  output logic [OW-1:0]              res_data
);

  seq_state_e                       r_state, w_state_nx;
  logic [1:0]                       r_w_cnt, w_w_cnt_nx;
  logic [1:0]                       r_i_cnt, w_i_cnt_nx;
  logic [N_WWORDS-1:0][WORD_W-1:0]  r_sa_w, w_sa_w_nx;
  logic [IN_W-1:0]                  r_sa_in, w_sa_in_nx;
  logic                             r_sa_en, w_sa_en_nx;
  logic                             r_cfg_ready, w_cfg_ready_nx;
  logic                             r_busy, w_busy_nx;
  logic                             r_done, w_done_nx;
  logic                             w_clr;
  logic                             w_hs;
  logic                             w_fin;

  assign w_hs = cfg_valid && r_cfg_ready;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_w_cnt     <= '0;
      r_i_cnt     <= '0;
      r_sa_w      <= '0;
      r_sa_in     <= '0;
      r_sa_en     <= 1'b0;
      r_cfg_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_w_cnt     <= w_w_cnt_nx;
      r_i_cnt     <= w_i_cnt_nx;
      r_sa_w      <= w_sa_w_nx;
      r_sa_in     <= w_sa_in_nx;
      r_sa_en     <= w_sa_en_nx;
      r_cfg_ready <= w_cfg_ready_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
    end
  end

  // Next state and next register values.
  always_comb begin
    w_state_nx = r_state;
    w_w_cnt_nx = r_w_cnt;
    w_i_cnt_nx = r_i_cnt;
    w_sa_w_nx  = r_sa_w;
    w_sa_in_nx = r_sa_in;
    w_sa_en_nx = 1'b0;
    w_clr      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_clr      = 1'b1;
          w_sa_w_nx  = '0;
          w_w_cnt_nx = '0;
          w_i_cnt_nx = '0;
          w_state_nx = ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (w_hs) begin
          w_sa_w_nx[r_w_cnt] = cfg_data;
          w_w_cnt_nx         = r_w_cnt + 2'd1;
          if (r_w_cnt == 2'(N_WWORDS - 1)) w_state_nx = ST_LOAD_I;
        end
      end
      ST_LOAD_I: begin
        // Without a handshake sa_in holds and sa_en drops, freezing the array.
        if (w_hs) begin
          w_sa_in_nx = cfg_data[IN_W-1:0];
          w_sa_en_nx = 1'b1;
          w_i_cnt_nx = r_i_cnt + 2'd1;
          if (r_i_cnt == 2'(N_IWORDS - 1)) w_state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Stop enabling once this cycle's capture completes every column.
        w_sa_in_nx = '0;
        if (w_fin) w_state_nx = ST_DONE;
        else       w_sa_en_nx = 1'b1;
      end
      default: w_state_nx = ST_IDLE;
    endcase
    w_cfg_ready_nx = (w_state_nx == ST_LOAD_W) || (w_state_nx == ST_LOAD_I);
    w_busy_nx      = w_cfg_ready_nx || (w_state_nx == ST_DRAIN);
    w_done_nx      = (r_state == ST_DRAIN) && (w_state_nx == ST_DONE);
  end

  res_capture #(
    .OW  (OW),
    .LAT (LAT)
  ) u_res_capture (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_en     (r_sa_en),
    .i_col0   (sa_out1),
    .i_col1   (sa_out2),
    .i_col2   (sa_out3),
    .i_addr   (res_addr),
    .o_data_c (res_data),
    .o_fin_c  (w_fin)
  );

  assign cfg_ready = r_cfg_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sa_en     = r_sa_en;
  assign sa_w      = r_sa_w;
  assign sa_in     = r_sa_in;

endmodule

// File: tb/tb_sysa_seq.sv
// tb_sysa_seq: directed bench for sysa_seq with a small behavioural 3x3 array
// (LAT=1): column k sees the input word k enabled cycles after column 0 and
// outputs sum_j x_j * W[j][k], where W[j][k] is byte k of weight word j.
module tb_sysa_seq;

  localparam int unsigned OW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [31:0]   cfg_data;
  logic          busy;
  logic          done;
  logic          sa_en;
  logic [95:0]   sa_w;
  logic [23:0]   sa_in;
  logic [OW-1:0] sa_out1, sa_out2, sa_out3;
  logic [3:0]    res_addr;
  logic [OW-1:0] res_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  sysa_seq #(.OW(OW), .LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .busy      (busy),
    .done      (done),
    .sa_en     (sa_en),
    .sa_w      (sa_w),
    .sa_in     (sa_in),
    .sa_out1   (sa_out1),
    .sa_out2   (sa_out2),
    .sa_out3   (sa_out3),
    .res_addr  (res_addr),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural array: row pipeline advancing only on enabled cycles.
  logic [23:0] p0, p1, p2;
  always @(posedge clk) begin
    if (rst) begin
      p0 <= '0; p1 <= '0; p2 <= '0;
    end else if (sa_en) begin
      p2 <= p1; p1 <= p0; p0 <= sa_in;
    end
  end

  function automatic logic [OW-1:0] col_out(input int k, input logic [23:0] x,
                                            input logic [95:0] w);
    int acc;
    acc = 0;
    for (int j = 0; j < 3; j++)
      acc += int'(x[8*j +: 8]) * int'(w[32*j + 8*k +: 8]);
    return OW'(acc);
  endfunction

  assign sa_out1 = col_out(0, p0, sa_w);
  assign sa_out2 = col_out(1, p1, sa_w);
  assign sa_out3 = col_out(2, p2, sa_w);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [8:0][OW-1:0] exp);
    for (int a = 0; a < 10; a++) begin
      res_addr = 4'(a);
      #1;
      if (a < 9) check($sformatf("%s[%0d]", tag, a), 128'(res_data), 128'(exp[a]));
      else       check($sformatf("%s[oob]", tag), 128'(res_data), 128'(0));
    end
    res_addr = '0;
  endtask

  // One job from IDLE/DONE; stall = idle cycles between inputs, glitch = start
  // pulses during LOAD_I and DRAIN.
  task automatic run_job(input logic [2:0][31:0] wv, input logic [2:0][23:0] iv,
                         input int stall, input bit glitch,
                         output int first_e, output int done_e, output int n_done);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ready_in_load_w", 128'(cfg_ready), 128'(1));
    check("busy_in_load_w", 128'(busy), 128'(1));
    check_res("res_cleared_at_start", '0);
    cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cfg_data = wv[i];
      tick();
    end
    check("sa_w_loaded", 128'(sa_w), 128'(wv));
    check("ready_in_load_i", 128'(cfg_ready), 128'(1));
    first_e = -1;
    for (int i = 0; i < 3; i++) begin
      cfg_data  = {8'hA5, iv[i]};
      cfg_valid = 1'b1;
      if (glitch && i == 1) start = 1'b1;
      tick();
      start = 1'b0;
      if (i == 0) first_e = cyc;
      check("sa_en_after_hs", 128'(sa_en), 128'(1));
      check("sa_in_after_hs", 128'(sa_in), 128'(iv[i]));
      if (stall > 0 && i < 2) begin
        cfg_valid = 1'b0;
        repeat (stall) begin
          tick();
          check("sa_en_stall", 128'(sa_en), 128'(0));
          check("sa_in_stall", 128'(sa_in), 128'(iv[i]));
        end
      end
    end
    check("ready_in_drain", 128'(cfg_ready), 128'(0));
    done_e = -1;
    n_done = 0;
    for (int n = 0; n < 20; n++) begin
      if (glitch && n == 1) start = 1'b1;
      tick();
      start = 1'b0;
      if (done) begin
        n_done++;
        if (done_e < 0) begin
          done_e = cyc;
          check("busy_at_done", 128'(busy), 128'(0));
          check("sa_en_at_done", 128'(sa_en), 128'(0));
        end
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [2:0][31:0]   wa, we;
    logic [2:0][23:0]   ia;
    logic [8:0][OW-1:0] ra, re;
    int f, d, nd;

    wa = {32'h0001_0000, 32'h0000_0100, 32'h0000_0001};
    we = {32'h0004_0000, 32'h0000_0300, 32'h0000_0102};
    ia = {24'h090807, 24'h060504, 24'h030201};
    // Identity weights: column k collects byte k of each input.
    ra = {16'd9, 16'd6, 16'd3, 16'd8, 16'd5, 16'd2, 16'd7, 16'd4, 16'd1};
    // col0 = 2*x0, col1 = x0 + 3*x1, col2 = 4*x2.
    re = {16'd36, 16'd24, 16'd12, 16'd31, 16'd19, 16'd7, 16'd14, 16'd8, 16'd2};

    rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; res_addr = '0;
    repeat (2) tick();
    check("rst_sa_en", 128'(sa_en), 128'(0));
    check("rst_sa_w", 128'(sa_w), 128'(0));
    check("rst_sa_in", 128'(sa_in), 128'(0));
    check("rst_cfg_ready", 128'(cfg_ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check_res("rst_res", '0);
    rst = 1'b0;
    cfg_valid = 1'b1;
    tick();
    check("idle_ready_ignores_valid", 128'(cfg_ready), 128'(0));
    cfg_valid = 1'b0;

    // Baseline job, no stalls.
    run_job(wa, ia, 0, 1'b0, f, d, nd);
    check("base_done_latency", 128'(d - f), 128'(6));
    check("base_done_count", 128'(nd), 128'(1));
    check("base_sa_w_held", 128'(sa_w), 128'(wa));
    check_res("base_res", ra);

    // Two-cycle stalls between inputs: done 4 cycles later, same results.
    run_job(wa, ia, 2, 1'b0, f, d, nd);
    check("stall_done_latency", 128'(d - f), 128'(10));
    check("stall_done_count", 128'(nd), 128'(1));
    check_res("stall_res", ra);

    // start while busy is ignored.
    run_job(wa, ia, 0, 1'b1, f, d, nd);
    check("glitch_done_latency", 128'(d - f), 128'(6));
    check("glitch_done_count", 128'(nd), 128'(1));
    check("glitch_idle_after", 128'(busy), 128'(0));
    check_res("glitch_res", ra);

    // Reset after the second input aborts the job.
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cfg_data = wa[i];
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      cfg_data = {8'h00, ia[i]};
      tick();
    end
    cfg_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_cfg_ready", 128'(cfg_ready), 128'(0));
    check("abort_sa_en", 128'(sa_en), 128'(0));
    check("abort_sa_w", 128'(sa_w), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    check_res("abort_res", '0);
    tick();

    run_job(wa, ia, 0, 1'b0, f, d, nd);
    check("post_abort_done_latency", 128'(d - f), 128'(6));
    check("post_abort_done_count", 128'(nd), 128'(1));
    check_res("post_abort_res", ra);

    // Back-to-back job from DONE with different weights.
    run_job(we, ia, 0, 1'b0, f, d, nd);
    check("b2b_done_latency", 128'(d - f), 128'(6));
    check("b2b_done_count", 128'(nd), 128'(1));
    check("b2b_sa_w_held", 128'(sa_w), 128'(we));
    check_res("b2b_res", re);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
